// File: rtl/seq_matcher_pkg.sv
// Shared definitions for the button-sequence recorder/matcher family:
// FSM state encoding and default pattern memory geometry.
package seq_matcher_pkg;

    localparam int unsigned SEQ_ADDR_W = 4;
    localparam int unsigned SEQ_DATA_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/seq_matcher_if.sv
// Control, press and pattern-memory signals between the game top and
// seq_matcher. The game top (or bench) uses master, the matcher uses slave.
interface seq_matcher_if
    import seq_matcher_pkg::*;
#(
    parameter int unsigned ADDR_W = SEQ_ADDR_W,
    parameter int unsigned DATA_W = SEQ_DATA_W
);

    logic [ADDR_W:0]   len;
    logic              start;
    logic              press_valid;
    logic [DATA_W-1:0] press_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              ready;
    logic              busy;
    logic [ADDR_W-1:0] pos;
    logic              done;
    logic              match;
    logic              timeout;

    modport master (
        output len, start, press_valid, press_data, rd_data,
        input  rd_en, rd_addr, ready, busy, pos, done, match, timeout
    );

    modport slave (
        input  len, start, press_valid, press_data, rd_data,
        output rd_en, rd_addr, ready, busy, pos, done, match, timeout
    );

endinterface

// File: rtl/seq_matcher_timer.sv
// Inter-press timer: loadable down-counter with a registered expired flag.
// Only built when SEQ_TIMEOUT_EN is defined; otherwise this file is empty.
`ifdef SEQ_TIMEOUT_EN
module seq_matcher_timer #(
    parameter int unsigned          CNT_W    = 24,
    parameter logic [CNT_W-1:0]     LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             expired_q;

    // Reload takes priority; otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter and expiry flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == '0);
        end
    end

    assign expired_o = expired_q;

endmodule
`endif

// File: rtl/seq_matcher.sv
// Plays back a stored button pattern from the pattern BRAM one entry at a
// time and checks debounced presses against it, reporting pass/fail.
// Optional inter-press timeout is enabled by defining SEQ_TIMEOUT_EN.
module seq_matcher
    import seq_matcher_pkg::*;
#(
    parameter int unsigned ADDR_W         = SEQ_ADDR_W,
    parameter int unsigned DATA_W         = SEQ_DATA_W,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic          clk,
    input  logic          rst,
    seq_matcher_if.slave  bus
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    seq_state_e        state_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] pos_q;
    logic [DATA_W-1:0] exp_q;
    logic              rd_en_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              match_q;
    logic              timeout_q;

    logic              start_ok_c;
    logic              last_c;
    logic              hit_c;

    // A zero-length timeout has no meaning; reject it at elaboration.
    if (TIMEOUT_CYCLES == 24'd0) begin : g_timeout_check
        $error("seq_matcher: TIMEOUT_CYCLES must be nonzero");
    end

    // start with len=0 is ignored in every state.
    assign start_ok_c = bus.start && (bus.len != '0);
    // Compare pos+1 against the latched length so len never underflows.
    assign last_c     = ((LEN_W'(pos_q) + LEN_W'(1)) == len_q);
    assign hit_c      = (bus.press_data == exp_q);

`ifdef SEQ_TIMEOUT_EN
    logic tmr_expired;

    // Reloaded in LOAD so the count starts fresh on every entry to WAIT.
    seq_matcher_timer #(
        .CNT_W    (24),
        .LOAD_VAL (TIMEOUT_CYCLES - 24'd1)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (state_q == ST_LOAD),
        .en_i      (state_q == ST_WAIT),
        .expired_o (tmr_expired)
    );
`endif

    // Match FSM; every output flag is updated alongside its state transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            pos_q     <= '0;
            exp_q     <= '0;
            rd_en_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (start_ok_c) begin
                // Start wins over a same-cycle press and aborts silently.
                state_q <= ST_FETCH;
                len_q   <= bus.len;
                pos_q   <= '0;
                match_q <= 1'b0;
                rd_en_q <= 1'b1;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    ST_FETCH: begin
                        state_q <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        exp_q   <= bus.rd_data;
                        state_q <= ST_WAIT;
                        ready_q <= 1'b1;
                    end
                    ST_WAIT: begin
                        if (bus.press_valid) begin
                            ready_q <= 1'b0;
                            if (!hit_c) begin
                                match_q <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else if (last_c) begin
                                match_q <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                pos_q   <= pos_q + ADDR_W'(1);
                                rd_en_q <= 1'b1;
                                state_q <= ST_FETCH;
                            end
                        end
`ifdef SEQ_TIMEOUT_EN
                        else if (tmr_expired) begin
                            ready_q   <= 1'b0;
                            match_q   <= 1'b0;
                            done_q    <= 1'b1;
                            timeout_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end
`endif
                    end
                    ST_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = pos_q;
    assign bus.ready   = ready_q;
    assign bus.busy    = busy_q;
    assign bus.pos     = pos_q;
    assign bus.done    = done_q;
    assign bus.match   = match_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_seq_matcher.sv
// Directed self-checking bench for seq_matcher with a registered-read
// pattern memory model. Define SEQ_TIMEOUT_EN to exercise the timeout path.
module tb_seq_matcher;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_matcher_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    seq_matcher #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] pat [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
    logic [DATA_W-1:0] mem [16];
    logic [ADDR_W-1:0] rd_log [$];
    int done_cnt = 0;
    int n_vec    = 0;
    int n_miss   = 0;

    // Pattern memory: data valid one cycle after rd_en; also log addresses and done pulses.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data <= mem[bus.rd_addr];
            rd_log.push_back(bus.rd_addr);
        end
        if (bus.done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W:0] l);
        bus.len   = l;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic press(input logic [DATA_W-1:0] d);
        bus.press_valid = 1'b1;
        bus.press_data  = d;
        tick();
        bus.press_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.ready && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.ready), 32'd1);
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < rd_log.size()) return 32'(rd_log[i]);
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        int d0;
        int n_rd;
        int n;
        bus.len         = '0;
        bus.start       = 1'b0;
        bus.press_valid = 1'b0;
        bus.press_data  = '0;
        for (int i = 0; i < 16; i++) mem[i] = pat[i % 4];

        // Reset state
        repeat (2) tick();
        chk("rst_rd_en",   32'(bus.rd_en),   32'd0);
        chk("rst_ready",   32'(bus.ready),   32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_done",    32'(bus.done),    32'd0);
        chk("rst_match",   32'(bus.match),   32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_pos",     32'(bus.pos),     32'd0);
        rst = 1'b0;
        tick();

        // Full correct pass, len=4, exact latencies
        rd_log.delete();
        pulse_start(5'd4);
        chk("t1_fetch_rd_en", 32'(bus.rd_en),   32'd1);
        chk("t1_fetch_addr",  32'(bus.rd_addr), 32'd0);
        chk("t1_fetch_busy",  32'(bus.busy),    32'd1);
        tick();
        chk("t1_load_ready",  32'(bus.ready),   32'd0);
        tick();
        chk("t1_ready_t3",    32'(bus.ready),   32'd1);
        press(2'd2);
        chk("t1_p1_rd_en",    32'(bus.rd_en),   32'd1);
        chk("t1_p1_pos",      32'(bus.pos),     32'd1);
        tick();
        tick();
        chk("t1_ready_p3",    32'(bus.ready),   32'd1);
        press(2'd1);
        wait_ready("t1_rdy3");
        press(2'd3);
        wait_ready("t1_rdy4");
        chk("t1_pos3", 32'(bus.pos), 32'd3);
        press(2'd0);
        chk("t1_done",    32'(bus.done),    32'd1);
        chk("t1_match",   32'(bus.match),   32'd1);
        chk("t1_pos_end", 32'(bus.pos),     32'd3);
        chk("t1_timeout", 32'(bus.timeout), 32'd0);
        chk("t1_busy_p1", 32'(bus.busy),    32'd1);
        tick();
        chk("t1_done_p2",  32'(bus.done),  32'd0);
        chk("t1_busy_p2",  32'(bus.busy),  32'd0);
        chk("t1_match_p2", 32'(bus.match), 32'd1);
        chk("t1_reads", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_rd_addr", log_at(i), 32'(i));

        // Wrong second press
        pulse_start(5'd4);
        wait_ready("t2_rdy1");
        press(2'd2);
        wait_ready("t2_rdy2");
        press(2'd3);
        chk("t2_done",    32'(bus.done),    32'd1);
        chk("t2_match",   32'(bus.match),   32'd0);
        chk("t2_timeout", 32'(bus.timeout), 32'd0);
        chk("t2_pos",     32'(bus.pos),     32'd1);
        tick();

        // start with len=0 is ignored
        n_rd = rd_log.size();
        d0   = done_cnt;
        pulse_start(5'd0);
        chk("t3_busy0",  32'(bus.busy),  32'd0);
        chk("t3_rd_en0", 32'(bus.rd_en), 32'd0);
        repeat (5) tick();
        chk("t3_busy",  32'(bus.busy),     32'd0);
        chk("t3_reads", 32'(rd_log.size()), 32'(n_rd));
        chk("t3_dones", 32'(done_cnt),      32'(d0));

        // Presses during FETCH/LOAD are dropped, len=1
        pulse_start(5'd1);
        bus.press_valid = 1'b1;
        bus.press_data  = 2'd3;
        tick();
        bus.press_data  = 2'd1;
        tick();
        bus.press_valid = 1'b0;
        chk("t4_ready", 32'(bus.ready), 32'd1);
        chk("t4_done0", 32'(bus.done),  32'd0);
        chk("t4_busy",  32'(bus.busy),  32'd1);
        press(2'd2);
        chk("t4_done",  32'(bus.done),  32'd1);
        chk("t4_match", 32'(bus.match), 32'd1);
        tick();

        // Asynchronous reset in WAIT at pos=2
        pulse_start(5'd4);
        wait_ready("t5_rdy1");
        press(2'd2);
        wait_ready("t5_rdy2");
        press(2'd1);
        wait_ready("t5_rdy3");
        chk("t5_pos2", 32'(bus.pos), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_rd_en",   32'(bus.rd_en),   32'd0);
        chk("t5_rst_ready",   32'(bus.ready),   32'd0);
        chk("t5_rst_busy",    32'(bus.busy),    32'd0);
        chk("t5_rst_done",    32'(bus.done),    32'd0);
        chk("t5_rst_match",   32'(bus.match),   32'd0);
        chk("t5_rst_timeout", 32'(bus.timeout), 32'd0);
        chk("t5_rst_pos",     32'(bus.pos),     32'd0);
        #1;
        rst = 1'b0;
        tick();
        rd_log.delete();
        pulse_start(5'd4);
        chk("t5_addr0", 32'(bus.rd_addr), 32'd0);
        chk("t5_rd_en", 32'(bus.rd_en),   32'd1);
        tick();
        chk("t5_first_read", log_at(0), 32'd0);

        // Hold in WAIT (or time out), then abort by restart with latched len
        wait_ready("t6_rdy1");
        press(2'd2);
        wait_ready("t6_rdy2");
        chk("t6_pos1", 32'(bus.pos), 32'd1);
`ifdef SEQ_TIMEOUT_EN
        pulse_start(5'd4);
        tick();
        tick();
        chk("t6_tmo_ready", 32'(bus.ready), 32'd1);
        repeat (15) tick();
        chk("t6_tmo_early", 32'(bus.done), 32'd0);
        tick();
        chk("t6_tmo_done",    32'(bus.done),    32'd1);
        chk("t6_tmo_timeout", 32'(bus.timeout), 32'd1);
        chk("t6_tmo_match",   32'(bus.match),   32'd0);
        tick();
        chk("t6_tmo_clear", 32'(bus.timeout), 32'd0);
        chk("t6_tmo_busy",  32'(bus.busy),    32'd0);
`else
        d0 = done_cnt;
        n  = 0;
        repeat (1100) begin
            tick();
            if (!bus.ready) n++;
        end
        chk("t6_hold_ready", 32'(n),           32'd0);
        chk("t6_hold_done",  32'(done_cnt),    32'(d0));
        chk("t6_timeout",    32'(bus.timeout), 32'd0);
`endif
        d0 = done_cnt;
        pulse_start(5'd2);
        bus.len = 5'd0;
        wait_ready("t6_rdy3");
        chk("t6_restart_pos", 32'(bus.pos), 32'd0);
        press(2'd2);
        wait_ready("t6_rdy4");
        chk("t6_abort_nodone", 32'(done_cnt), 32'(d0));
        press(2'd1);
        chk("t6_done",  32'(bus.done),  32'd1);
        chk("t6_match", 32'(bus.match), 32'd1);
        chk("t6_pos",   32'(bus.pos),   32'd1);
        tick();

        // Maximum length, final pos = 15, len changed mid-attempt
        rd_log.delete();
        pulse_start(5'd16);
        bus.len = 5'd3;
        for (int i = 0; i < 16; i++) begin
            wait_ready("t7_rdy");
            chk("t7_pos", 32'(bus.pos), 32'(i));
            press(pat[i % 4]);
        end
        chk("t7_done",  32'(bus.done),      32'd1);
        chk("t7_match", 32'(bus.match),     32'd1);
        chk("t7_pos15", 32'(bus.pos),       32'd15);
        chk("t7_reads", 32'(rd_log.size()), 32'd16);
        tick();
        chk("t7_busy", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global time bound
    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/seq_matcher.md
# seq_matcher

Playback-side counterpart to the button sequence recorder. Reads a previously stored button pattern out of the pattern BRAM one entry at a time and checks a player's debounced button presses against it. Reports pass or fail on the first wrong press or after the last correct one. Sits between the debouncers and the shared pattern memory in the Simon-style game top.

## Interface

Parameters:
- ADDR_W, 4: pattern memory address width; maximum sequence length is 2^ADDR_W.
- DATA_W, 2: width of one pattern entry (one bit per button).
- TIMEOUT_CYCLES, 24'd12_000_000: inter-press timeout, about 1 s at 12 MHz; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- len  in  ADDR_W+1  number of stored entries (0..2^ADDR_W); sampled only when start is accepted.
- start  in  1  one-cycle pulse; begins a match attempt.
- press_valid  in  1  one-cycle strobe from the debouncers: a button press occurred.
- press_data  in  DATA_W  button levels accompanying press_valid.
- rd_en  out  1  pattern memory read enable.
- rd_addr  out  ADDR_W  pattern memory read address.
- rd_data  in  DATA_W  pattern memory read data, valid one cycle after rd_en.
- ready  out  1  high while waiting for a press.
- busy  out  1  high in any state other than IDLE.
- pos  out  ADDR_W  index of the entry currently expected.
- done  out  1  one-cycle pulse when an attempt ends.
- match  out  1  result level; valid from done until the next accepted start.
- timeout  out  1  one-cycle pulse, coincident with done, when the attempt failed on the timeout.

## Operation

- States:
  - IDLE
  - FETCH: drive rd_en=1, rd_addr=pos.
  - LOAD: latch rd_data into the expected register.
  - WAIT: ready=1.
  - DONE: pulse done, then return to IDLE.
- IDLE:
  - start with len≠0: latch len, set pos=0, clear match, go to FETCH.
  - start with len=0: ignored.
- WAIT, press_valid:
  - press_data ≠ expected: match=0, go to DONE.
  - press_data = expected and pos = len−1: match=1, go to DONE.
  - Otherwise: pos+1, go to FETCH.
- press_valid outside WAIT is dropped; it does not count as a press and does not cause a failure.
- start while busy aborts the current attempt with no done pulse and restarts from pos=0 using the newly sampled len.
- If start and press_valid arrive in the same cycle, start wins.
- The pos comparison uses the latched len. Changing len mid-attempt has no effect.
- len = 2^ADDR_W is legal; the final pos is 2^ADDR_W−1. pos never wraps.
- Reset, including mid-attempt: state=IDLE, pos=0, and rd_en, ready, busy, done, match and timeout all 0.

## Timing

- start accepted at cycle T: FETCH at T+1, LOAD at T+2, ready=1 from T+3.
- After a correct non-final press at cycle P, the block is ready again at P+3.
- A decisive press at cycle P gives done=1 at P+1. match is valid at P+1.
- busy falls at P+2.
- All outputs are registered or decoded from the state register. There is no combinational path from press_* to done or match.

## Configuration

- SEQ_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and counts while in WAIT.
  - When it reaches TIMEOUT_CYCLES−1 with no press, the block goes to DONE with match=0 and timeout=1.
  - A press in the expiry cycle takes priority over the timeout.
- SEQ_TIMEOUT_EN undefined: WAIT lasts indefinitely, timeout is tied to 0, and no counter logic is built.

## Structure

- Shared package/include seq_defs:
  - State encoding localparams (IDLE, FETCH, LOAD, WAIT, DONE).
  - Default ADDR_W and DATA_W, also used by the recorder and the memory.
- Sub-module seq_timer: loadable down-counter with clear and expired outputs.
  - Instantiated only under SEQ_TIMEOUT_EN.

## Test plan

- Memory holds 2,1,3,0 and len=4. start, then presses 2,1,3,0 each once ready is high → done at the cycle after the fourth press, match=1, pos=3, four reads at addresses 0..3.
- Same pattern, presses 2,3 → done after the second press, match=0, timeout=0, pos=1.
- start with len=0 → busy stays 0, no rd_en, no done.
- press_valid during FETCH/LOAD, then the correct press in WAIT with len=1 → the early press is ignored and the attempt passes, match=1.
- Assert rst during WAIT at pos=2 → all outputs 0 immediately. start after release reads address 0 first.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, start and no press → done and timeout pulse 16 cycles after ready rises, match=0. Without the macro, the block stays in WAIT for over 1000 cycles.
